// File: rtl/mv_store_ctrl_if.sv
// Handshake bundle between the motion-estimation core, mv_store_ctrl and the MV store memory.
// mv_*: vector push side (valid/ready). mem_*: write side (mem_wr_en/mem_ready).
// slave = mv_store_ctrl view, master = the surrounding logic (ME core + memory).
interface mv_store_ctrl_if #(
    parameter int ADDR_W = 11
);
    logic              mv_valid;
    logic [3:0]        mvx;
    logic [3:0]        mvy;
    logic              mv_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ready;

    modport master (
        output mv_valid, mvx, mvy, mem_ready,
        input  mv_ready, mem_wr_en, mem_addr, mem_wdata
    );

    modport slave (
        input  mv_valid, mvx, mvy, mem_ready,
        output mv_ready, mem_wr_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mv_store_ctrl.sv
// Purpose: buffers 4b/4b motion vectors, packs them to {mvy,mvx} bytes and writes them to the MV store in raster block order.
// Latency: vector accepted at edge N -> mem_wr_en high after edge N+1 (FIFO write, then registered write port).
// Backpressure: mv_ready = RUN && FIFO not full; write port holds addr/data while mem_ready=0.
// Ports: clk, rst_n (sync, active low), frame_start, bus (mv_* push side, mem_* write side),
//        blk_x/blk_y (next block to write), busy, frame_done (1-cycle), overflow (sticky).
// Optional: define MV_STATS_EN to add zero_mv_cnt / max_abs_mv per-frame statistics outputs.
module mv_store_ctrl #(
    parameter int                FRAME_W_BLK = 4,
    parameter int                FRAME_H_BLK = 4,
    parameter int                ADDR_W      = 11,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                FIFO_DEPTH  = 4,
    localparam int               BX_W        = (FRAME_W_BLK > 1) ? $clog2(FRAME_W_BLK) : 1,
    localparam int               BY_W        = (FRAME_H_BLK > 1) ? $clog2(FRAME_H_BLK) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    mv_store_ctrl_if.slave       bus,
    output logic [BX_W-1:0]      blk_x,
    output logic [BY_W-1:0]      blk_y,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overflow
`ifdef MV_STATS_EN
    ,
    output logic [ADDR_W-1:0]    zero_mv_cnt,
    output logic [3:0]           max_abs_mv
`endif
);

    localparam int TOTAL = FRAME_W_BLK * FRAME_H_BLK;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
    localparam logic [BX_W-1:0]  BX_LAST  = BX_W'(FRAME_W_BLK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, head_ptr;
    logic [OCC_W-1:0]  occ;
    logic [CNT_W-1:0]  push_cnt, wr_cnt;
    logic [ADDR_W-1:0] addr_cnt;

    // Registered write port. The presented entry stays counted in occ until
    // the memory accepts it, so FIFO_DEPTH is the total buffering.
    logic              out_vld;
    logic [7:0]        out_dat;
    logic [ADDR_W-1:0] out_addr;
    logic              ovf;

    logic active, fifo_full, push, pop, last_push, last_pop, start;
    logic head_avail, load;

    assign active    = (state == RUN) || (state == FLUSH);
    assign fifo_full = (occ == OCC_FULL);
    assign push      = bus.mv_valid && bus.mv_ready;
    assign pop       = out_vld && bus.mem_ready;
    assign last_push = push && (push_cnt == LAST_IDX);
    assign last_pop  = pop && (wr_cnt == LAST_IDX);
    assign start     = (state == IDLE) && frame_start;

    // Next head to present: the entry behind the one leaving, or the current
    // head if nothing is presented. This cycle's push is deliberately not
    // forwarded, which gives the fixed one-cycle FIFO-to-port latency.
    assign head_ptr   = pop ? (rd_ptr + PTR_W'(1)) : rd_ptr;
    assign head_avail = pop ? (occ > OCC_W'(1)) : (occ != '0);
    assign load       = active && (!out_vld || pop);

    assign bus.mem_wr_en = out_vld;
    assign bus.mem_wdata = out_dat;
    assign bus.mem_addr  = out_addr;
    assign overflow      = ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bus.mv_ready = 1'b0;
        busy         = 1'b0;
        frame_done   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) state_nxt = RUN;
            end
            RUN: begin
                bus.mv_ready = !fifo_full;
                busy         = 1'b1;
                if (last_push) state_nxt = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (last_pop) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Data array needs no reset: occupancy and pointers qualify every read.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {bus.mvy, bus.mvx};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            push_cnt <= '0;
            wr_cnt   <= '0;
            addr_cnt <= BASE_ADDR;
            blk_x    <= '0;
            blk_y    <= '0;
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_addr <= '0;
            ovf      <= 1'b0;
        end else begin
            if (start) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                occ      <= '0;
                push_cnt <= '0;
                wr_cnt   <= '0;
                addr_cnt <= BASE_ADDR;
                blk_x    <= '0;
                blk_y    <= '0;
                out_vld  <= 1'b0;
                ovf      <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr   <= wr_ptr + PTR_W'(1);
                    push_cnt <= push_cnt + CNT_W'(1);
                end
                case ({push, pop})
                    2'b10:   occ <= occ + OCC_W'(1);
                    2'b01:   occ <= occ - OCC_W'(1);
                    default: ;
                endcase
                if (pop) begin
                    rd_ptr   <= rd_ptr + PTR_W'(1);
                    wr_cnt   <= wr_cnt + CNT_W'(1);
                    addr_cnt <= addr_cnt + ADDR_W'(1);
                    // Final write returns the coordinates to the origin so
                    // they already read 0 while frame_done is high.
                    if (last_pop) begin
                        blk_x <= '0;
                        blk_y <= '0;
                    end else if (blk_x == BX_LAST) begin
                        blk_x <= '0;
                        blk_y <= blk_y + BY_W'(1);
                    end else begin
                        blk_x <= blk_x + BX_W'(1);
                    end
                end
                if (load) begin
                    out_vld <= head_avail;
                    if (head_avail) begin
                        out_dat  <= fifo_mem[head_ptr];
                        out_addr <= pop ? (addr_cnt + ADDR_W'(1)) : addr_cnt;
                    end
                end
            end
            // Any vector offered while not accepted is lost; flag it.
            if (bus.mv_valid && !bus.mv_ready) ovf <= 1'b1;
        end
    end

`ifdef MV_STATS_EN
    logic [ADDR_W-1:0] run_zero;
    logic [3:0]        run_max;
    logic [3:0]        abs_x, abs_y, pair_max, pop_max;
    logic              is_zero;

    // Two's-complement magnitude; -8 maps naturally to 4'h8.
    always_comb begin
        abs_x    = out_dat[3] ? (~out_dat[3:0] + 4'd1) : out_dat[3:0];
        abs_y    = out_dat[7] ? (~out_dat[7:4] + 4'd1) : out_dat[7:4];
        pair_max = (abs_x > abs_y) ? abs_x : abs_y;
        pop_max  = (pair_max > run_max) ? pair_max : run_max;
        is_zero  = (out_dat == 8'd0);
    end

    // Published on the final write so the values are valid alongside frame_done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_zero    <= '0;
            run_max     <= '0;
            zero_mv_cnt <= '0;
            max_abs_mv  <= '0;
        end else if (start) begin
            run_zero <= '0;
            run_max  <= '0;
        end else if (pop) begin
            run_zero <= run_zero + ADDR_W'(is_zero);
            run_max  <= pop_max;
            if (last_pop) begin
                zero_mv_cnt <= run_zero + ADDR_W'(is_zero);
                max_abs_mv  <= pop_max;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mv_store_ctrl.sv
// Directed bench for mv_store_ctrl: default instance (BASE_ADDR=0) and a wrap instance (BASE_ADDR=2040).
// Expected bytes/addresses come from the bench's own vector tables.
module tb_mv_store_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       fs_a, fs_b;
    logic [1:0] bx_a, by_a, bx_b, by_b;
    logic       busy_a, busy_b, fd_a, fd_b, ovf_a, ovf_b;
`ifdef MV_STATS_EN
    logic [10:0] zc_a, zc_b;
    logic [3:0]  mx_a, mx_b;
`endif

    mv_store_ctrl_if #(.ADDR_W(11)) bus_a ();
    mv_store_ctrl_if #(.ADDR_W(11)) bus_b ();

    mv_store_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_a), .bus(bus_a),
        .blk_x(bx_a), .blk_y(by_a), .busy(busy_a), .frame_done(fd_a), .overflow(ovf_a)
`ifdef MV_STATS_EN
        , .zero_mv_cnt(zc_a), .max_abs_mv(mx_a)
`endif
    );

    mv_store_ctrl #(.BASE_ADDR(11'd2040)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_b), .bus(bus_b),
        .blk_x(bx_b), .blk_y(by_b), .busy(busy_b), .frame_done(fd_b), .overflow(ovf_b)
`ifdef MV_STATS_EN
        , .zero_mv_cnt(zc_b), .max_abs_mv(mx_b)
`endif
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [3:0] vx [16];
    logic [3:0] vy [16];

    // Monitors: sample handshakes mid-cycle, away from the active edge.
    int          pc_a = 0, wc_a = 0, fc_a = 0, pc_b = 0, wc_b = 0, fc_b = 0;
    logic [10:0] wa_addr [$];
    logic [7:0]  wa_dat  [$];
    logic [10:0] wb_addr [$];
    logic [7:0]  wb_dat  [$];
    logic        held_a = 1'b0;
    logic [10:0] h_addr;
    logic [7:0]  h_dat;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_a.mv_valid && bus_a.mv_ready) pc_a++;
            if (bus_a.mem_wr_en && bus_a.mem_ready) begin
                wc_a++;
                wa_addr.push_back(bus_a.mem_addr);
                wa_dat.push_back(bus_a.mem_wdata);
            end
            if (fd_a) fc_a++;
            if (held_a) begin
                chk("hold_en", bus_a.mem_wr_en, 1);
                chk("hold_addr", bus_a.mem_addr, h_addr);
                chk("hold_dat", bus_a.mem_wdata, h_dat);
            end
            held_a = bus_a.mem_wr_en && !bus_a.mem_ready;
            h_addr = bus_a.mem_addr;
            h_dat  = bus_a.mem_wdata;
            if (bus_b.mv_valid && bus_b.mv_ready) pc_b++;
            if (bus_b.mem_wr_en && bus_b.mem_ready) begin
                wc_b++;
                wb_addr.push_back(bus_b.mem_addr);
                wb_dat.push_back(bus_b.mem_wdata);
            end
            if (fd_b) fc_b++;
        end else begin
            held_a = 1'b0;
        end
    end

    // One frame on the default instance. stall_len: mem_ready low for the first
    // cycles; extra: keep offering a 17th vector after all 16 accepted;
    // rst_after: assert rst_n once this many writes completed; lat: check latency.
    task automatic run_a(input int stall_len, input bit extra, input int rst_after, input bit lat);
        int p0, w0, f0, idx, cyc;
        bit blk_done;
        p0 = pc_a; w0 = wc_a; f0 = fc_a; cyc = 0; blk_done = 0;
        @(posedge clk); #1 fs_a = 1'b1;
        @(posedge clk); #1 fs_a = 1'b0;
        chk("busy_run", busy_a, 1);
        chk("ovf_clr", ovf_a, 0);
        chk("rdy_run", bus_a.mv_ready, 1);
        while (fc_a == f0 && cyc < 400) begin
            @(posedge clk); #1;
            idx = pc_a - p0;
            if (lat && idx == 1) chk("lat_edge_n", bus_a.mem_wr_en, 0);
            if (lat && idx == 2) chk("lat_edge_n1", bus_a.mem_wr_en, 1);
            if (stall_len > 0 && cyc == stall_len) begin
                chk("stall_acc", idx, 4);
                chk("stall_rdy", bus_a.mv_ready, 0);
            end
            if (!blk_done && (wc_a - w0) == 5) begin
                chk("blk_x5", bx_a, 1);
                chk("blk_y5", by_a, 1);
                blk_done = 1;
            end
            if (rst_after > 0 && (wc_a - w0) == rst_after) begin
                rst_n = 1'b0;
                bus_a.mv_valid = 1'b0;
                break;
            end
            bus_a.mv_valid  = (idx < 16 && bus_a.mv_ready) || (extra && idx >= 16 && busy_a);
            bus_a.mvx       = (idx < 16) ? vx[idx] : 4'h0;
            bus_a.mvy       = (idx < 16) ? vy[idx] : 4'h0;
            bus_a.mem_ready = (cyc >= stall_len);
            cyc++;
        end
        bus_a.mv_valid  = 1'b0;
        bus_a.mem_ready = 1'b1;
        if (rst_after > 0) chk("rst_reach", wc_a - w0, rst_after);
        else               chk("frame_done_cnt", fc_a - f0, 1);
    endtask

    task automatic check_frame_a(input int w0);
        chk("wr_cnt", wc_a - w0, 16);
        for (int i = 0; i < 16; i++) begin
            if (w0 + i < wa_addr.size()) begin
                chk($sformatf("addr%0d", i), wa_addr[w0 + i], i);
                chk($sformatf("dat%0d", i), wa_dat[w0 + i], {vy[i], vx[i]});
            end
        end
        chk("end_blk_x", bx_a, 0);
        chk("end_blk_y", by_a, 0);
        chk("end_busy", busy_a, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    int w0, f0, p0, idx_b;

    initial begin
        rst_n = 1'b0; fs_a = 1'b0; fs_b = 1'b0;
        bus_a.mv_valid = 1'b0; bus_a.mvx = '0; bus_a.mvy = '0; bus_a.mem_ready = 1'b1;
        bus_b.mv_valid = 1'b0; bus_b.mvx = '0; bus_b.mvy = '0; bus_b.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", bus_a.mem_wr_en, 0);
        chk("rst_ready", bus_a.mv_ready, 0);
        chk("rst_addr", bus_a.mem_addr, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", fd_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_blk", {bx_a, by_a}, 0);
        rst_n = 1'b1;

        // Frame 1: mvx=i, mvy=15-i, memory always ready.
        for (int i = 0; i < 16; i++) begin vx[i] = 4'(i); vy[i] = 4'(15 - i); end
        w0 = wc_a;
        run_a(0, 0, 0, 1);
        check_frame_a(w0);
        chk("f1_ovf", ovf_a, 0);

        // Frame 2: memory stalled 10 cycles at start.
        for (int i = 0; i < 16; i++) begin vx[i] = 4'(3 * i); vy[i] = 4'(i); end
        w0 = wc_a;
        run_a(10, 0, 0, 0);
        check_frame_a(w0);
        chk("f2_ovf", ovf_a, 0);

        // Overflow: vector offered in IDLE, then a 17th in FLUSH.
        w0 = wc_a;
        @(posedge clk); #1 bus_a.mv_valid = 1'b1; bus_a.mvx = 4'h7; bus_a.mvy = 4'h7;
        @(posedge clk); #1 bus_a.mv_valid = 1'b0;
        chk("idle_ovf", ovf_a, 1);
        chk("idle_no_wr", wc_a - w0, 0);
        for (int i = 0; i < 16; i++) begin vx[i] = 4'((i % 3) + 1); vy[i] = 4'h1; end
        vx[0] = 4'h0; vy[0] = 4'h0;
        vx[5] = 4'h0; vy[5] = 4'h0;
        vx[9] = 4'h0; vy[9] = 4'h0;
        vx[12] = 4'b1000;
        w0 = wc_a;
        run_a(0, 1, 0, 0);
        check_frame_a(w0);
        chk("flush_ovf", ovf_a, 1);
`ifdef MV_STATS_EN
        chk("zero_mv_cnt", zc_a, 3);
        chk("max_abs_mv", mx_a, 8);
`endif

        // Reset after 7 writes, then a clean frame from BASE_ADDR.
        for (int i = 0; i < 16; i++) begin vx[i] = 4'(15 - i); vy[i] = 4'(i ^ 5); end
        f0 = fc_a;
        run_a(0, 0, 7, 0);
        @(posedge clk); #1;
        chk("mrst_wr_en", bus_a.mem_wr_en, 0);
        chk("mrst_busy", busy_a, 0);
        chk("mrst_ready", bus_a.mv_ready, 0);
        chk("mrst_addr", bus_a.mem_addr, 0);
        chk("mrst_dat", bus_a.mem_wdata, 0);
        chk("mrst_blk", {bx_a, by_a}, 0);
        chk("mrst_ovf", ovf_a, 0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("mrst_no_done", fc_a - f0, 0);
        w0 = wc_a;
        run_a(0, 0, 0, 0);
        check_frame_a(w0);

        // Address wrap on the BASE_ADDR=2040 instance.
        for (int i = 0; i < 16; i++) begin vx[i] = 4'(i); vy[i] = 4'(~i); end
        w0 = wc_b; p0 = pc_b; f0 = fc_b;
        @(posedge clk); #1 fs_b = 1'b1;
        @(posedge clk); #1 fs_b = 1'b0;
        for (int c = 0; c < 400 && fc_b == f0; c++) begin
            @(posedge clk); #1;
            idx_b = pc_b - p0;
            bus_b.mv_valid = (idx_b < 16) && bus_b.mv_ready;
            bus_b.mvx = (idx_b < 16) ? vx[idx_b] : 4'h0;
            bus_b.mvy = (idx_b < 16) ? vy[idx_b] : 4'h0;
        end
        bus_b.mv_valid = 1'b0;
        chk("wrap_done", fc_b - f0, 1);
        chk("wrap_cnt", wc_b - w0, 16);
        for (int i = 0; i < 16; i++) begin
            if (w0 + i < wb_addr.size()) begin
                chk($sformatf("wrap_addr%0d", i), wb_addr[w0 + i], (2040 + i) % 2048);
                chk($sformatf("wrap_dat%0d", i), wb_dat[w0 + i], {vy[i], vx[i]});
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
